// File: rtl/module_sender_burst.sv
// Burst sender: streams a run of consecutive memory words to a receiver over a four-phase Req/Ack link.
// Optional even-parity output on DataOut is built when SENDER_PARITY_EN is defined.
module module_sender_burst #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  Clock_i,
    input  logic                  Reset_i,
    input  logic                  Transmit_i,
    input  logic [ADDR_WIDTH-1:0] StartAddr_i,
    input  logic [ADDR_WIDTH-1:0] Length_i,
    output logic                  Ready_o,
    output logic                  ReadEnable_o,
    output logic [ADDR_WIDTH-1:0] Address_o,
    input  logic [DATA_WIDTH-1:0] DataIn_i,
    output logic [DATA_WIDTH-1:0] DataOut_o,
    output logic                  Req_o,
    input  logic                  Ack_i,
    output logic                  Done_o
`ifdef SENDER_PARITY_EN
    ,
    output logic                  DataParity_o
`endif
);

    typedef enum logic [2:0] {IDLE, READ, LOAD, REQ, REL} state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = 1;
    localparam logic [ADDR_WIDTH:0]   REMAIN_ONE = 1;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH:0]     remain_q, remain_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    done_q, done_d;

    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end

    // A zero Length means a full sweep of the address space, hence the extra counter bit.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        data_d   = data_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (Transmit_i) begin
                    addr_d = StartAddr_i;
                    if (Length_i == '0)
                        remain_d = {1'b1, {ADDR_WIDTH{1'b0}}};
                    else
                        remain_d = {1'b0, Length_i};
                    state_d = READ;
                end
            end
            READ: state_d = LOAD;
            LOAD: begin
                data_d  = DataIn_i;
                state_d = REQ;
            end
            REQ: begin
                if (Ack_i)
                    state_d = REL;
            end
            REL: begin
                if (!Ack_i) begin
                    if (remain_q == REMAIN_ONE) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        addr_d   = addr_q + ADDR_ONE;
                        remain_d = remain_q - REMAIN_ONE;
                        state_d  = READ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign Ready_o      = (state_q == IDLE);
    assign ReadEnable_o = (state_q == READ);
    assign Req_o        = (state_q == REQ);
    assign Address_o    = addr_q;
    assign DataOut_o    = data_q;
    assign Done_o       = done_q;

`ifdef SENDER_PARITY_EN
    logic parity_q;

    // Parity is taken from the next-state word so it changes on the same edge as DataOut.
    always_ff @(posedge Clock_i) begin
        if (Reset_i)
            parity_q <= 1'b0;
        else
            parity_q <= ^data_d;
    end

    assign DataParity_o = parity_q;
`endif

endmodule

// File: tb/tb_module_sender_burst.sv
// Scoreboard bench for module_sender_burst: expected reads and words are queued by the stimulus
// and consumed by a monitor whenever the DUT strobes a read or raises Req.
module tb_module_sender_burst;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          Transmit = 1'b0;
    logic [AW-1:0] StartAddr = '0;
    logic [AW-1:0] Length = '0;
    logic          Ready_o;
    logic          ReadEnable_o;
    logic [AW-1:0] Address_o;
    logic [DW-1:0] DataIn_i = '0;
    logic [DW-1:0] DataOut_o;
    logic          Req_o;
    logic          Ack_i = 1'b0;
    logic          Done_o;
`ifdef SENDER_PARITY_EN
    logic          DataParity_o;
`endif

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;
    int doneCount = 0;
    int expDone = 0;
    int lastReadCycle = 0;
    int lastReqRise = 0;
    int lastDoneCycle = 0;
    int txCycle = 0;
    int ackDelay = 1;
    int ackCnt = 0;
    int expReqLen = 2;
    logic          reqPrev = 1'b0;
    logic          donePrev = 1'b0;
    logic [DW-1:0] heldData = '0;
    logic [DW-1:0] mem [16];
    logic [AW-1:0] expAddr [$];
    logic [DW-1:0] expData [$];

    module_sender_burst #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clock_i      (Clock),
        .Reset_i      (Reset),
        .Transmit_i   (Transmit),
        .StartAddr_i  (StartAddr),
        .Length_i     (Length),
        .Ready_o      (Ready_o),
        .ReadEnable_o (ReadEnable_o),
        .Address_o    (Address_o),
        .DataIn_i     (DataIn_i),
        .DataOut_o    (DataOut_o),
        .Req_o        (Req_o),
        .Ack_i        (Ack_i),
        .Done_o       (Done_o)
`ifdef SENDER_PARITY_EN
        ,
        .DataParity_o (DataParity_o)
`endif
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cycle <= cycle + 1;

    // One-cycle-latency memory and a receiver whose Ack follows Req after ackDelay edges.
    always @(posedge Clock) begin
        if (ReadEnable_o)
            DataIn_i <= mem[Address_o];
        if (Req_o != Ack_i) begin
            if (ackCnt + 1 >= ackDelay) begin
                Ack_i  <= Req_o;
                ackCnt <= 0;
            end else begin
                ackCnt <= ackCnt + 1;
            end
        end else begin
            ackCnt <= 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: consumes the scoreboard on every read strobe and every Req rising edge.
    always @(negedge Clock) begin
        if (!Reset) begin
            if (ReadEnable_o) begin
                lastReadCycle = cycle;
                if (expAddr.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected read: got address %0h, expected no read", Address_o);
                end else begin
                    checkOutput("read address", Address_o, expAddr.pop_front());
                end
            end
            if (Req_o && !reqPrev) begin
                lastReqRise = cycle;
                heldData = DataOut_o;
                if (expData.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected req: got data %0h, expected no word", DataOut_o);
                end else begin
                    logic [DW-1:0] want;
                    want = expData.pop_front();
                    checkOutput("dataout", DataOut_o, want);
`ifdef SENDER_PARITY_EN
                    checkOutput("parity", DataParity_o, ^want);
`endif
                end
            end else if (Req_o && reqPrev) begin
                checkOutput("dataout stable", DataOut_o, heldData);
            end
            if (!Req_o && reqPrev)
                checkOutput("req high cycles", cycle - lastReqRise, expReqLen);
            if (Done_o) begin
                doneCount++;
                lastDoneCycle = cycle;
                checkOutput("ready with done", Ready_o, 1);
            end
            if (Done_o && donePrev)
                checkOutput("done single cycle", 0, 1);
        end
        reqPrev  = Req_o;
        donePrev = Done_o;
    end

    task automatic tick();
        @(negedge Clock);
        #1;
    endtask

    task automatic applyStimulus(input int start, input int len);
        StartAddr = start[AW-1:0];
        Length    = len[AW-1:0];
        Transmit  = 1'b1;
        txCycle   = cycle + 1;
        tick();
        Transmit  = 1'b0;
    endtask

    task automatic pushBurst(input int start, input int len, input bit countsDone);
        int n;
        n = (len == 0) ? 16 : len;
        for (int i = 0; i < n; i++) begin
            int a;
            a = (start + i) % 16;
            expAddr.push_back(a[AW-1:0]);
            expData.push_back(mem[a]);
        end
        if (countsDone)
            expDone++;
    endtask

    task automatic waitDone();
        for (int i = 0; i < 2000 && doneCount < expDone; i++)
            tick();
        checkOutput("done count", doneCount, expDone);
        checkOutput("reads outstanding", expAddr.size(), 0);
        checkOutput("words outstanding", expData.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++)
            mem[i] = 16'h0;
        mem[3] = 16'h00A5;

        repeat (3) tick();
        checkOutput("reset ready", Ready_o, 1);
        checkOutput("reset readenable", ReadEnable_o, 0);
        checkOutput("reset req", Req_o, 0);
        checkOutput("reset done", Done_o, 0);
        checkOutput("reset address", Address_o, 0);
        checkOutput("reset dataout", DataOut_o, 0);
        Reset = 1'b0;
        tick();

        // Single word with timing relative to the Transmit edge
        pushBurst(3, 1, 1);
        applyStimulus(3, 1);
        waitDone();
        checkOutput("read latency", lastReadCycle, txCycle);
        checkOutput("req latency", lastReqRise, txCycle + 2);
        checkOutput("done after read", lastDoneCycle, lastReadCycle + 6);
        tick();
        checkOutput("ready after burst", Ready_o, 1);
        checkOutput("dataout retained", DataOut_o, 16'h00A5);
        checkOutput("address retained", Address_o, 3);

        for (int i = 0; i < 16; i++)
            mem[i] = 16'(i + 1);

        // Address wrap 14,15,0,1
        pushBurst(14, 4, 1);
        applyStimulus(14, 4);
        waitDone();
        tick();
        checkOutput("wrap last address", Address_o, 1);
        checkOutput("wrap last data", DataOut_o, 2);

        // Length 0 sends the whole memory
        pushBurst(5, 0, 1);
        applyStimulus(5, 0);
        waitDone();
        tick();
        checkOutput("full last address", Address_o, 4);
        checkOutput("full last data", DataOut_o, 5);

        // Slow receiver plus a stray Transmit while Req is up
        ackDelay  = 5;
        expReqLen = 6;
        pushBurst(2, 2, 1);
        applyStimulus(2, 2);
        for (int i = 0; i < 50 && !Req_o; i++)
            tick();
        checkOutput("slow req seen", Req_o, 1);
        Transmit = 1'b1;
        tick();
        Transmit = 1'b0;
        waitDone();
        repeat (10) tick();
        checkOutput("slow single done", doneCount, expDone);
        ackDelay  = 1;
        expReqLen = 2;

        // Reset in the middle of a handshake aborts the burst without Done
        pushBurst(7, 1, 0);
        applyStimulus(7, 3);
        for (int i = 0; i < 50 && !(Req_o && Ack_i); i++)
            tick();
        checkOutput("req and ack seen", Req_o && Ack_i, 1);
        Reset = 1'b1;
        tick();
        checkOutput("abort req", Req_o, 0);
        checkOutput("abort ready", Ready_o, 1);
        checkOutput("abort dataout", DataOut_o, 0);
        checkOutput("abort address", Address_o, 0);
        Reset = 1'b0;
        repeat (10) tick();
        checkOutput("abort no done", doneCount, expDone);
        checkOutput("abort reads outstanding", expAddr.size(), 0);
        pushBurst(0, 2, 1);
        applyStimulus(0, 2);
        waitDone();

        // Parity words
        mem[8] = 16'h0007;
        mem[9] = 16'h0003;
        pushBurst(8, 2, 1);
        applyStimulus(8, 2);
        waitDone();
        tick();
        checkOutput("parity burst last data", DataOut_o, 16'h0003);
`ifdef SENDER_PARITY_EN
        checkOutput("parity of 0003", DataParity_o, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/module_sender_burst.md
# module_sender_burst

Parametrised burst sender that reads a block of words from a synchronous memory and forwards them one by one to a receiver over a four-phase Req/Ack handshake. It replaces the fixed 16-bit single-word sender: data width and address width are parameters, a transfer covers a programmable run of consecutive addresses, and end-of-burst is signalled by a Done pulse. It sits between the local data memory (read port) and the inter-block link toward the receiver.

## Interface
- DATA_WIDTH, 16, width of memory words and of DataOut
- ADDR_WIDTH, 4, memory address width; depth = 2^ADDR_WIDTH words
- Clock  in  1  single system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- Transmit  in  1  start request, sampled only while Ready=1
- StartAddr  in  ADDR_WIDTH  first address of burst, latched with Transmit
- Length  in  ADDR_WIDTH  words in burst; 0 means 2^ADDR_WIDTH words
- Ready  out  1  high while idle and able to accept Transmit
- ReadEnable  out  1  memory read strobe, one cycle per word
- Address  out  ADDR_WIDTH  memory read address
- DataIn  in  DATA_WIDTH  memory read data, valid the cycle after ReadEnable
- DataOut  out  DATA_WIDTH  word presented to receiver, stable while Req=1
- Req  out  1  four-phase request to receiver
- Ack  in  1  four-phase acknowledge from receiver
- Done  out  1  one-cycle pulse after last word's handshake completes
- DataParity  out  1  even parity of DataOut (only with SENDER_PARITY_EN)

## Operation
- States: IDLE, READ, LOAD, REQ, REL. All outputs registered or decoded from state only.
- IDLE: Ready=1. Transmit=1 -> latch StartAddr into address counter, Length into remaining counter (0 loaded as 2^ADDR_WIDTH, counter is ADDR_WIDTH+1 bits) -> READ.
- READ: ReadEnable=1, Address=current address, exactly one cycle -> LOAD.
- LOAD: DataIn captured into DataOut at end of cycle -> REQ.
- REQ: Req=1, DataOut held. Ack=1 -> REL; else stay.
- REL: Req=0. Ack=0 -> if remaining=1: Done=1 next cycle, -> IDLE; else address+1 (modulo 2^ADDR_WIDTH, wraps 2^ADDR_WIDTH-1 -> 0), remaining-1, -> READ. Ack still 1 -> stay.
- Transmit while not IDLE ignored (no queueing). Ack in IDLE/READ/LOAD ignored.
- DataOut retains last sent word after burst; Address retains last read address.
- Reset: state IDLE, Ready=1, ReadEnable=0, Req=0, Done=0, Address=0, DataOut=0, DataParity=0, counters 0. Reset mid-burst aborts immediately; Req drops at the reset edge regardless of Ack; no Done.

## Timing
- Transmit sampled at edge t0 -> ReadEnable=1 in cycle t0+1, DataOut valid and Req=1 in cycle t0+3.
- Receiver with zero-wait Ack (Ack follows Req by one cycle, same for release): Req high 2 cycles, REL 2 cycles; per-word period 6 cycles (READ, LOAD, REQ x2, REL x2).
- Done high for the single cycle in which state returns to IDLE (same cycle Ready rises); Transmit sampled in that cycle starts a new burst.
- Req never rises while Ack=1 from a previous word (guaranteed by REL wait).
- Memory read latency fixed at 1 cycle; no backpressure on read port.

## Configuration
- SENDER_PARITY_EN defined: DataParity port present, = XOR of DataOut, registered with DataOut (same edge), reset 0.
- Not defined: DataParity port and logic absent; all other behaviour identical.

## Test plan
- Single word: memory[3]=16'h00A5, StartAddr=3, Length=1, pulse Transmit, Ack echoes Req with 1-cycle delay -> ReadEnable once at Address=3, DataOut=16'h00A5 with Req, Done pulse 6 cycles after ReadEnable, Ready back to 1.
- Wrap: StartAddr=14, Length=4, memory[i]=i+1 -> Address sequence 14,15,0,1; DataOut 15,16,1,2; exactly four Req pulses then one Done.
- Full depth: Length=0 -> 16 words sent, addresses StartAddr..StartAddr+15 mod 16, Done once.
- Slow/busy: Ack delayed 5 cycles; Transmit pulsed during REQ -> Req held 6 cycles with DataOut stable, second Transmit ignored (single Done, no extra reads).
- Reset mid-handshake: assert Reset while Req=1 and Ack=1 -> next cycle Req=0, Ready=1, DataOut=0, Done never pulses; new burst afterwards runs normally.
- Parity (SENDER_PARITY_EN): DataOut=16'h0007 -> DataParity=1; 16'h0003 -> 0; without macro bench compiles without the port.
